fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial drain stage that sits directly downstream of the register-based FIFO (`regb_fifo`). It pops one word at a time through the FIFO read handshake (`empty` / `shift_out` / `rdata`) and emits each word as an asynchronous serial frame: start bit, LSB-first data, optional parity, stop bit. It is the consumer that closes the FIFO datapath towards an off-chip UART-style link.

## Interface
- `WIDTH`, 8: data word width; must match the FIFO `WIDTH`.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 0 selects even parity and 1 selects odd parity.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `res_n` in 1: reset, synchronous, active-low.
- `empty` in 1: FIFO empty flag.
- `rdata` in WIDTH: FIFO head word; valid whenever `empty`=0.
- `shift_out` out 1: FIFO pop; the head word is removed at the rising edge where it is 1.
- `tx` out 1: serial line, registered; idle level is 1.
- `busy` out 1: 1 whenever a frame is in progress (state ≠ IDLE).
- `frame_done` out 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- **FIFO read handshake (first-word-fall-through):**
  - `rdata` is valid combinationally while `empty`=0.
  - `shift_out`=1 for exactly one cycle consumes that word at the same edge.
- **`shift_out` decode:** combinational, `shift_out = res_n && (state==IDLE) && !empty`. It is never asserted when `empty`=1 or during reset.
- **State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE.**
  - **IDLE:** `tx`=1. When `shift_out`=1, at that edge load `rdata` into the shift register, compute parity, clear the bit counters, set `tx`←0 and go to START.
  - **START:** hold `tx`=0 for CLKS_PER_BIT cycles. Then `tx`←sreg[0] and go to DATA.
  - **DATA:** each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift sreg right and increment the bit index. After bit WIDTH−1, go to PARITY if `PARITY_EN`, otherwise to STOP.
  - **PARITY:** `tx` = XOR of the data bits XOR `PARITY_ODD`, for CLKS_PER_BIT cycles. Then go to STOP.
  - **STOP:** `tx`=1 for CLKS_PER_BIT cycles. `frame_done`=1 in the final cycle of STOP. Then go to IDLE.
- **Counters:**
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT−1 and wraps to 0 at each bit boundary.
  - Bit index is $clog2(WIDTH) bits wide. It is not allowed to wrap inside a frame.
- **Back-to-back frames:** after STOP the block always spends exactly one cycle in IDLE. If `empty`=0 in that cycle, it pops immediately.
- **Empty FIFO:** remain in IDLE with `tx`=1 and `shift_out`=0. No spurious frame is sent.
- **`empty` changes mid-frame:** ignored. `empty` is sampled only in IDLE.
- **Reset (`res_n`=0 at a rising edge), including mid-frame:**
  - State→IDLE, `tx`→1, counters→0, sreg→0.
  - `busy`=0 and `frame_done`=0.
  - `shift_out`=0 while `res_n`=0.
  - A word already popped is discarded, not retransmitted.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `frame_done`=0, `shift_out`=0.
- **Pop to start bit:** if the pop occurs at edge E, `tx` goes low for the cycle following E.
- **Frame length:** F = CLKS_PER_BIT × (WIDTH + 2 + PARITY_EN) cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- **Back-to-back period:** F + 1 cycles.
- **`busy`:** goes high in the first start-bit cycle and low in the IDLE cycle after STOP.
- **Bit timing:** each data bit k (LSB = k=0) is on `tx` during cycles [CLKS_PER_BIT×(1+k), CLKS_PER_BIT×(2+k)−1], counted relative to the first start-bit cycle.

## Test plan
All scenarios use WIDTH=8 and CLKS_PER_BIT=4 unless noted.

- **Reset:** hold `res_n`=0 with `empty`=0 → `shift_out`=0, `tx`=1, `busy`=0 throughout; no pop occurs.
- **Single word 0xA5, PARITY_EN=0:**
  - Exactly one `shift_out` pulse.
  - `tx` sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - Frame lasts 40 cycles; one `frame_done` pulse, in the 40th cycle.
- **Parity, 0xA5:**
  - PARITY_EN=1, PARITY_ODD=0 → parity bit 0; frame lasts 44 cycles.
  - PARITY_ODD=1 → parity bit 1.
- **Burst drain:**
  - Fill a depth-5 FIFO with random data, then release → 5 frames with start bits exactly 41 cycles apart.
  - Deserialized words equal the written words in order.
  - `empty`=1 afterwards, `tx` stays 1, no extra `shift_out`.
- **Reset mid-frame:** assert `res_n`=0 for one edge during DATA bit 3, FIFO still non-empty →
  - `tx`=1 and `busy`=0 after that edge.
  - After release, the next FIFO word starts a fresh, complete frame.
- **Empty toggling:** `empty` goes 0 for a single cycle while the block is in DATA → no pop occurs until the block is back in IDLE.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains a first-word-fall-through FIFO one word at a time and
//            serialises each word as start / LSB-first data / [parity] / stop.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             shift_out,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] C_BIT_LAST  = IW'(WIDTH - 1);
    localparam logic          C_PAR_INIT  = (PARITY_ODD != 0);
    localparam logic          C_PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;

    logic              w_baud_last;
    logic [WIDTH-1:0]  w_sreg_shr;

    assign w_baud_last = (baud_q == C_BAUD_LAST);
    assign w_sreg_shr  = sreg_q >> 1;

    // The pop is only offered from IDLE, so empty is ignored mid-frame.
    assign shift_out  = res_n & (state_q == S_IDLE) & ~empty;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) & w_baud_last;

    always_comb begin
        state_d = state_q;
        baud_d  = w_baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        par_d   = par_q;
        tx_d    = tx_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (shift_out) begin
                    sreg_d  = rdata;
                    par_d   = (^rdata) ^ C_PAR_INIT;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    tx_d    = sreg_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    // The bit index stops at the last bit instead of wrapping.
                    if (bit_q == C_BIT_LAST) begin
                        if (C_PAR_EN) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        sreg_d = w_sreg_shr;
                        bit_d  = bit_q + 1'b1;
                        tx_d   = w_sreg_shr[0];
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_last) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
`default_nettype wire
